uart_rx_cmd: RTL and testbench

- UART receiver and command parser: the receive counterpart of the existing UART transmit path.
- Runs on the 32 MHz UART clock and decodes 8N1 bytes from the host.
- Assembles fixed 5-byte command frames and updates run-time registers: the LMS reference word and a control word.
- Replaces the hard-wired LMS reference constant in the top level; outputs connect directly to lsm_top.data_ref and the control consumers.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_byte.sv | 111 +++++++++++
 rtl/uart_rx_cmd.sv | 132 +++++++++++++
 tb/tb_uart_rx_cmd.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART command receiver.
package uart_pkg;
  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam logic [7:0] ADDR_REF  = 8'h00;
  localparam logic [7:0] ADDR_CTRL = 8'h01;

  localparam logic [1:0] ERR_CSUM  = 2'd1;
  localparam logic [1:0] ERR_ADDR  = 2'd2;
  localparam logic [1:0] ERR_FRAME = 2'd3;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [2:0] {P_HDR, P_ADDR, P_DHI, P_DLO, P_SUM} prs_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, mid-bit sampling FSM, byte and framing-error pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frm_err_o,
  output logic       idle_o
);
  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

  logic        sync1_q, rxs_q;
  rx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shr_q, shr_d;
  logic [7:0]  byte_q, byte_d;
  logic        vld_q, vld_d;
  logic        ferr_q, ferr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shr_q   <= '0;
      byte_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd_i;
      rxs_q   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  // cnt_q counts down to the next sample point; a sample is taken when it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shr_d   = shr_q;
    byte_d  = byte_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = HALF_M1;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!rxs_q) begin
          cnt_d   = FULL_M1;
          bit_d   = 3'd0;
          state_d = RX_DATA;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shr_d = {rxs_q, shr_q[7:1]};
          cnt_d = FULL_M1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rxs_q) begin
          byte_d  = shr_q;
          vld_d   = 1'b1;
          state_d = RX_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rxs_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = vld_q;
  assign frm_err_o    = ferr_q;
  assign idle_o       = (state_q == RX_IDLE);
endmodule

// File: rtl/uart_rx_cmd.sv
// UART command receiver: parses A5/ADDR/DHI/DLO/SUM frames into the reference and control registers.
module uart_rx_cmd
  import uart_pkg::*;
#(
  parameter int          BAUD_DIV     = 32,
  parameter int          TIMEOUT_BITS = 40,
  parameter logic [15:0] REF_RESET    = 16'h012A,
  parameter logic [15:0] CTRL_RESET   = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rxd_i,
  output logic [15:0] data_ref_o,
  output logic [15:0] ctrl_o,
  output logic        upd_o,
  output logic [7:0]  upd_addr_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o
);
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_BITS * BAUD_DIV);

  logic       rx_vld, rx_ferr, rx_idle;
  logic [7:0] rx_byte;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rxd_i        (rxd_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_vld),
    .frm_err_o    (rx_ferr),
    .idle_o       (rx_idle)
  );

  prs_state_t  prs_q, prs_d;
  logic [7:0]  addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [31:0] tmo_q, tmo_d;
  logic [15:0] ref_q, ref_d, ctrl_q, ctrl_d;
  logic        upd_q, upd_d, err_q, err_d;
  logic [7:0]  upd_addr_q, upd_addr_d;
  logic [1:0]  err_code_q, err_code_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prs_q      <= P_HDR;
      addr_q     <= '0;
      dhi_q      <= '0;
      dlo_q      <= '0;
      tmo_q      <= '0;
      ref_q      <= REF_RESET;
      ctrl_q     <= CTRL_RESET;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      upd_addr_q <= '0;
      err_code_q <= '0;
    end else begin
      prs_q      <= prs_d;
      addr_q     <= addr_d;
      dhi_q      <= dhi_d;
      dlo_q      <= dlo_d;
      tmo_q      <= tmo_d;
      ref_q      <= ref_d;
      ctrl_q     <= ctrl_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      upd_addr_q <= upd_addr_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    prs_d      = prs_q;
    addr_d     = addr_q;
    dhi_d      = dhi_q;
    dlo_d      = dlo_q;
    ref_d      = ref_q;
    ctrl_d     = ctrl_q;
    upd_d      = 1'b0;
    err_d      = 1'b0;
    upd_addr_d = upd_addr_q;
    err_code_d = err_code_q;

    // Timeout counts clocks since the last byte; paused while a byte is being received.
    if (prs_q == P_HDR)  tmo_d = '0;
    else if (rx_idle)    tmo_d = tmo_q + 32'd1;
    else                 tmo_d = tmo_q;

    if (rx_vld) begin
      tmo_d = 32'd1;
      case (prs_q)
        P_HDR:  if (rx_byte == FRAME_HDR) prs_d = P_ADDR;
        P_ADDR: begin addr_d = rx_byte; prs_d = P_DHI; end
        P_DHI:  begin dhi_d  = rx_byte; prs_d = P_DLO; end
        P_DLO:  begin dlo_d  = rx_byte; prs_d = P_SUM; end
        P_SUM: begin
          prs_d = P_HDR;
          if ((addr_q ^ dhi_q ^ dlo_q) != rx_byte) begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end else if (addr_q == ADDR_REF) begin
            ref_d      = {dhi_q, dlo_q};
            upd_d      = 1'b1;
            upd_addr_d = addr_q;
          end else if (addr_q == ADDR_CTRL) begin
            ctrl_d     = {dhi_q, dlo_q};
            upd_d      = 1'b1;
            upd_addr_d = addr_q;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_ADDR;
          end
        end
        default: prs_d = P_HDR;
      endcase
    end else if (rx_ferr || tmo_d == TMO_LIMIT) begin
      prs_d      = P_HDR;
      err_d      = 1'b1;
      err_code_d = ERR_FRAME;
    end
  end

  assign data_ref_o   = ref_q;
  assign ctrl_o       = ctrl_q;
  assign upd_o        = upd_q;
  assign upd_addr_o   = upd_addr_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign byte_o       = rx_byte;
  assign byte_valid_o = rx_vld;
endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed bench for uart_rx_cmd with a frame-level reference model checked every clock.
module tb_uart_rx_cmd;
  localparam int BAUD = 32;
  localparam int TMO  = 40 * BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [15:0] data_ref_o, ctrl_o;
  logic        upd_o, err_o, byte_valid_o;
  logic [7:0]  upd_addr_o, byte_o;
  logic [1:0]  err_code_o;

  uart_rx_cmd #(
    .BAUD_DIV(BAUD), .TIMEOUT_BITS(40), .REF_RESET(16'h012A), .CTRL_RESET(16'h0000)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rxd_i(rxd),
    .data_ref_o(data_ref_o), .ctrl_o(ctrl_o),
    .upd_o(upd_o), .upd_addr_o(upd_addr_o),
    .err_o(err_o), .err_code_o(err_code_o),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Bytes the stimulus has sent with a good stop bit, consumed in order by the monitor.
  logic [7:0] sent [256];
  int wr_idx = 0, rd_idx = 0;
  int frm_armed = 0, frm_seen = 0;

  // Frame-level model state.
  logic [7:0]  fb [5];
  int          m_idx = 0;
  logic [15:0] m_ref = 16'h012A, m_ctrl = 16'h0000;
  logic        pend_upd = 1'b0, pend_err = 1'b0;
  logic [7:0]  pend_addr = 8'h00;
  logic [15:0] pend_data = 16'h0000;
  logic [1:0]  pend_code = 2'd0;
  int          tmo_cnt = 0;

  longint cyc = 0, last_bv = 0, last_upd = 0, last_err = 0;
  logic [1:0] last_code = 2'd0;
  int bv_cnt = 0, err_cnt = 0, upd_cnt = 0;

  always @(negedge clk) begin : monitor
    logic       e_upd, e_err;
    logic [1:0] e_code;
    logic [7:0] e_addr, b;
    cyc++;
    if (rst) begin
      m_ref = 16'h012A; m_ctrl = 16'h0000; m_idx = 0; tmo_cnt = 0;
      pend_upd = 1'b0; pend_err = 1'b0;
      rd_idx = wr_idx; frm_seen = frm_armed;
    end else begin
      e_upd = pend_upd; e_err = pend_err; e_code = pend_code; e_addr = pend_addr;
      if (pend_upd) begin
        if (pend_addr == 8'h00) m_ref = pend_data;
        else                    m_ctrl = pend_data;
      end
      pend_upd = 1'b0; pend_err = 1'b0;
      if (m_idx != 0) begin
        tmo_cnt++;
        if (tmo_cnt == TMO) begin e_err = 1'b1; e_code = 2'd3; m_idx = 0; end
      end
      // A bad-stop byte was sent: its single code-3 error may land at any clock.
      if (err_o === 1'b1 && err_code_o === 2'd3 && !e_err && frm_seen < frm_armed) begin
        frm_seen++; m_idx = 0; e_err = 1'b1; e_code = 2'd3;
      end
      n_cmp++;
      if (upd_o !== e_upd || err_o !== e_err || (e_upd && upd_addr_o !== e_addr) ||
          (e_err && err_code_o !== e_code)) begin
        n_fail++;
        $display("FAIL pulse cyc=%0d: upd=%b addr=%h err=%b code=%0d, required upd=%b addr=%h err=%b code=%0d",
                 cyc, upd_o, upd_addr_o, err_o, err_code_o, e_upd, e_addr, e_err, e_code);
      end
      n_cmp++;
      if (data_ref_o !== m_ref || ctrl_o !== m_ctrl) begin
        n_fail++;
        $display("FAIL regs cyc=%0d: ref=%h ctrl=%h, required ref=%h ctrl=%h",
                 cyc, data_ref_o, ctrl_o, m_ref, m_ctrl);
      end
      if (upd_o === 1'b1) begin upd_cnt++; last_upd = cyc; end
      if (err_o === 1'b1) begin err_cnt++; last_err = cyc; last_code = err_code_o; end
      if (byte_valid_o === 1'b1) begin
        bv_cnt++; last_bv = cyc; n_cmp++;
        if (rd_idx == wr_idx) begin
          n_fail++;
          $display("FAIL byte_unexp cyc=%0d: got byte %h, required no byte", cyc, byte_o);
        end else begin
          b = sent[rd_idx];
          rd_idx++;
          if (byte_o !== b) begin
            n_fail++;
            $display("FAIL byte cyc=%0d: got %h, required %h", cyc, byte_o, b);
          end
          tmo_cnt = 0;
          if (m_idx == 0) begin
            if (b == 8'hA5) m_idx = 1;
          end else begin
            fb[m_idx] = b;
            m_idx++;
            if (m_idx == 5) begin
              m_idx = 0;
              if ((fb[1] ^ fb[2] ^ fb[3]) != fb[4]) begin
                pend_err = 1'b1; pend_code = 2'd1;
              end else if (fb[1] <= 8'h01) begin
                pend_upd = 1'b1; pend_addr = fb[1]; pend_data = {fb[2], fb[3]};
              end else begin
                pend_err = 1'b1; pend_code = 2'd2;
              end
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    if (good_stop) begin sent[wr_idx] = b; wr_idx++; end
    else frm_armed++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(good_stop);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] s);
    send_byte(8'hA5, 1'b1);
    send_byte(a, 1'b1);
    send_byte(h, 1'b1);
    send_byte(l, 1'b1);
    send_byte(s, 1'b1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    int bv0, err0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ref", 32'(data_ref_o), 32'h012A);
    check("rst_ctrl", 32'(ctrl_o), 32'h0000);
    check("rst_byte", 32'(byte_o), 32'h00);
    check("rst_upd_addr", 32'(upd_addr_o), 32'h00);
    check("rst_err_code", 32'(err_code_o), 32'h0);

    repeat (10000) @(posedge clk);
    #1;
    check("idle_no_pulses", 32'(bv_cnt + err_cnt + upd_cnt), 32'd0);

    send_frame(8'h00, 8'h12, 8'h34, 8'h26);
    check("ref_write", 32'(data_ref_o), 32'h1234);
    check("ref_bytes", 32'(bv_cnt), 32'd5);
    check("ref_upd_cnt", 32'(upd_cnt), 32'd1);
    check("ref_upd_latency", 32'(last_upd - last_bv), 32'd1);

    send_frame(8'h01, 8'h00, 8'h03, 8'h00);
    check("csum_code", 32'(last_code), 32'd1);
    check("csum_ctrl", 32'(ctrl_o), 32'h0000);

    send_frame(8'h02, 8'h00, 8'h00, 8'h02);
    check("addr_code", 32'(last_code), 32'd2);
    check("addr_err_cnt", 32'(err_cnt), 32'd2);
    check("addr_no_upd", 32'(upd_cnt), 32'd1);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (1400) @(posedge clk);
    #1;
    check("tmo_latency", 32'(last_err - last_bv), 32'd1280);
    check("tmo_code", 32'(last_code), 32'd3);
    send_frame(8'h00, 8'hAB, 8'hCD, 8'h66);
    check("tmo_recover_ref", 32'(data_ref_o), 32'hABCD);

    bv0 = bv_cnt; err0 = err_cnt;
    send_byte(8'h3C, 1'b0);
    repeat (20 * BAUD) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("break_err_cnt", 32'(err_cnt - err0), 32'd1);
    check("break_code", 32'(last_code), 32'd3);
    check("break_no_byte", 32'(bv_cnt - bv0), 32'd0);
    send_frame(8'h01, 8'h00, 8'h05, 8'h04);
    check("break_recover_ctrl", 32'(ctrl_o), 32'h0005);

    bv0 = bv_cnt; err0 = err_cnt;
    rxd = 1'b0;
    repeat (BAUD / 2) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("glitch_no_byte", 32'(bv_cnt - bv0), 32'd0);
    check("glitch_no_err", 32'(err_cnt - err0), 32'd0);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_ref", 32'(data_ref_o), 32'h012A);
    check("midrst_ctrl", 32'(ctrl_o), 32'h0000);
    send_byte(8'h5A, 1'b1);
    send_frame(8'h01, 8'hBE, 8'hEF, 8'h50);
    check("post_rst_ctrl", 32'(ctrl_o), 32'hBEEF);
    check("post_rst_ref", 32'(data_ref_o), 32'h012A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
